// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_pkg                                                          |
// | Purpose  : Shared definitions for the SD sector staging buffer: FSM state  |
// |            encoding, sector size, operation codes and the idle bus byte.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sd_pkg;

    localparam int         SECTOR_BYTES = 512;
    localparam logic       OP_READ      = 1'b0;
    localparam logic       OP_WRITE     = 1'b1;
    localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } sd_state_t;

endpackage
`default_nettype wire

// File: rtl/sector_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sector_ram                                                      |
// | Purpose  : Single-port synchronous RAM holding one sector, registered read |
// |            (read-before-write). Only the read register is reset; the       |
// |            array itself keeps its contents across reset.                   |
// | Ports    : clk, rst     - clock, synchronous active-high reset             |
// |            addr         - byte address                                     |
// |            we, wdata    - write strobe and data                            |
// |            rdata        - data at the previous cycle's address             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sector_ram
    import sd_pkg::*;
#(
    parameter int DEPTH  = SECTOR_BYTES,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sd_sector_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_sector_buffer                                                |
// | Purpose  : Host-facing 512-byte sector staging buffer in front of          |
// |            sd_card_controller. Host owns the buffer in IDLE; during a      |
// |            transfer the byte counter owns it, streaming bytes out on a     |
// |            WRITE and capturing bytes on a READ.                            |
// | Ports    : host_*            - host buffer port and sector request/status |
// |            op_code, execute, sector_address - controller command          |
// |            outgoing_byte, incoming_byte      - controller data            |
// |            finished_byte, finished_sector, ctrl_busy - controller status  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sd_sector_buffer
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int SECTOR_BYTES   = sd_pkg::SECTOR_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  host_addr,
    input  logic        host_wr_en,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    input  logic        host_req,
    input  logic        host_op,
    input  logic [25:0] host_sector,
    output logic        host_ready,
    output logic        host_done,
    output logic        host_err,
    output logic        op_code,
    output logic        execute,
    output logic [25:0] sector_address,
    output logic [7:0]  outgoing_byte,
    input  logic [7:0]  incoming_byte,
    input  logic        finished_byte,
    input  logic        finished_sector,
    input  logic        ctrl_busy
);

    localparam int               c_tmo_w        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last   = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       c_sector_bytes = 10'(SECTOR_BYTES);

    sd_state_t           r_state;
    sd_state_t           w_state_nxt;
    logic                r_op;
    logic [25:0]         r_sector;
    logic [9:0]          r_byte_cnt;
    logic [9:0]          w_byte_cnt_nxt;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic [c_tmo_w-1:0]  w_tmo_inc;
    logic                r_err;

    logic                w_accept;
    logic                w_byte_take;
    logic                w_tmo_hit;

    logic [8:0]          w_ram_addr;
    logic                w_ram_we;
    logic [7:0]          w_ram_wdata;
    logic [7:0]          w_ram_rdata;

    assign host_ready     = (r_state == ST_IDLE) && !ctrl_busy;
    assign w_accept       = host_ready && host_req;
    assign w_byte_take    = (r_state == ST_XFER) && finished_byte &&
                            (r_byte_cnt < c_sector_bytes);
    assign w_byte_cnt_nxt = r_byte_cnt + {9'd0, w_byte_take};
    assign w_tmo_inc      = r_tmo_cnt + 1'b1;
    // Leave XFER on the edge where the counter would reach TIMEOUT_CYCLES-1,
    // so the DONE cycle lands TIMEOUT_CYCLES cycles after the last byte strobe.
    assign w_tmo_hit      = (r_state == ST_XFER) && !w_byte_take &&
                            (w_tmo_inc == c_tmo_last);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        execute     = 1'b0;
        host_done   = 1'b0;
        host_err    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                execute     = 1'b1;
                w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (finished_sector || w_tmo_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                host_done   = 1'b1;
                host_err    = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Request latch, counters, sticky error ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_READ;
            r_sector   <= '0;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_op       <= host_op;
            r_sector   <= host_sector;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
        end else if (r_state == ST_XFER) begin
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_byte_take) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= w_tmo_inc;
            end
            // Overrun byte, short/long sector (judged after the coincident
            // byte has been counted) and timeout all latch the error.
            if ((finished_byte && !w_byte_take) ||
                (finished_sector && (w_byte_cnt_nxt != c_sector_bytes)) ||
                w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign op_code        = r_op;
    assign sector_address = r_sector;

    // ---------------- Buffer port ownership ----------------
    // In IDLE/DONE the host drives the RAM. On acceptance the address is
    // pulled to 0 (unless the host is writing that cycle) so buf[0] is
    // already on the read register during the execute cycle. On a WRITE
    // the RAM is addressed with the upcoming count so the read register
    // always holds buf[byte_cnt]; on a READ it is addressed with the
    // current count so the captured byte lands in the strobe cycle.
    always_comb begin
        w_ram_addr  = host_addr;
        w_ram_we    = 1'b0;
        w_ram_wdata = host_wdata;
        if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            if (w_accept && !host_wr_en) begin
                w_ram_addr = '0;
            end
            w_ram_we = (r_state == ST_IDLE) && host_wr_en;
        end else begin
            w_ram_wdata = incoming_byte;
            if (r_op == OP_READ) begin
                w_ram_addr = r_byte_cnt[8:0];
                w_ram_we   = w_byte_take;
            end else begin
                w_ram_addr = w_byte_cnt_nxt[8:0];
            end
        end
    end

    sector_ram #(
        .DEPTH  (SECTOR_BYTES),
        .ADDR_W (9),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .addr  (w_ram_addr),
        .we    (w_ram_we),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    assign host_rdata    = w_ram_rdata;
    assign outgoing_byte = (((r_state == ST_ISSUE) || (r_state == ST_XFER)) &&
                            (r_op == OP_WRITE) && (r_byte_cnt < c_sector_bytes))
                           ? w_ram_rdata : SD_IDLE_BYTE;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sd_sector_buffer                                             |
// | Purpose  : Self-checking bench for sd_sector_buffer: table of sector       |
// |            operations with a controller model, a shadow buffer model with  |
// |            a readback scoreboard queue, plus timeout/reset/busy sequences. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sd_sector_buffer;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  host_addr;
    logic        host_wr_en;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_req;
    logic        host_op;
    logic [25:0] host_sector;
    logic        host_ready;
    logic        host_done;
    logic        host_err;
    logic        op_code;
    logic        execute;
    logic [25:0] sector_address;
    logic [7:0]  outgoing_byte;
    logic [7:0]  incoming_byte;
    logic        finished_byte;
    logic        finished_sector;
    logic        ctrl_busy;

    always #5 clk = ~clk;

    sd_sector_buffer #(
        .TIMEOUT_CYCLES (100),
        .SECTOR_BYTES   (512)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_addr       (host_addr),
        .host_wr_en      (host_wr_en),
        .host_wdata      (host_wdata),
        .host_rdata      (host_rdata),
        .host_req        (host_req),
        .host_op         (host_op),
        .host_sector     (host_sector),
        .host_ready      (host_ready),
        .host_done       (host_done),
        .host_err        (host_err),
        .op_code         (op_code),
        .execute         (execute),
        .sector_address  (sector_address),
        .outgoing_byte   (outgoing_byte),
        .incoming_byte   (incoming_byte),
        .finished_byte   (finished_byte),
        .finished_sector (finished_sector),
        .ctrl_busy       (ctrl_busy)
    );

    int errors   = 0;
    int n_checks = 0;
    int done_count = 0;

    logic [7:0] mdl [0:511];
    logic [7:0] rd_q [$];

    typedef struct {
        logic        op;
        logic [25:0] sec;
        int          nbytes;
        int          mode;     // 0: fs after bytes, 1: fs with last byte, 2: none
        int          seed;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    always @(negedge clk) begin
        if (host_done === 1'b1) done_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'((i * 3 + seed) & 255);
    endfunction

    // Scoreboard readback: expected pushed with the address, popped one cycle later.
    task automatic readback(input int addr);
        logic [7:0] exp;
        host_addr = 9'(addr);
        rd_q.push_back(mdl[addr]);
        tick();
        exp = rd_q.pop_front();
        check($sformatf("rdata[%0d]", addr), {24'd0, host_rdata}, {24'd0, exp});
    endtask

    task automatic do_sector(input logic op, input logic [25:0] sec, input int nbytes,
                             input int mode, input int seed,
                             output logic err_seen, output int lat);
        int         k;
        int         bad;
        logic [7:0] exp;
        k = 0;
        while (!host_ready && k < 100) begin
            tick();
            k++;
        end
        host_req = 1'b1; host_op = op; host_sector = sec;
        tick();
        host_req = 1'b0;
        check("execute", {31'd0, execute}, 32'd1);
        check("op_code", {31'd0, op_code}, {31'd0, op});
        check("sector_address", {6'd0, sector_address}, {6'd0, sec});
        if (op == OP_WRITE)
            check("outgoing_first", {24'd0, outgoing_byte}, {24'd0, mdl[0]});
        tick();
        check("execute_pulse", {31'd0, execute}, 32'd0);
        bad = 0;
        lat = 0;
        for (int i = 0; i < nbytes; i++) begin
            exp = (i < 512) ? mdl[i] : 8'hFF;
            if (op == OP_WRITE && outgoing_byte !== exp) begin
                if (bad == 0)
                    $display("  byte %0d: outgoing 0x%0h vs 0x%0h", i, outgoing_byte, exp);
                bad++;
            end
            incoming_byte = (i < 512) ? pat(i, seed) : 8'hA5;
            finished_byte = 1'b1;
            if (mode == 1 && i == nbytes - 1) finished_sector = 1'b1;
            tick();
            finished_byte   = 1'b0;
            finished_sector = 1'b0;
            if (op == OP_READ && i < 512) mdl[i] = pat(i, seed);
            lat = 1;
            if (!(mode == 1 && i == nbytes - 1)) begin
                tick();
                lat = 2;
            end
        end
        if (mode == 0) begin
            finished_sector = 1'b1;
            tick();
            finished_sector = 1'b0;
            lat = 1;
        end
        while (host_done !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        err_seen = host_err;
        tick();
        check("done_single_pulse", {31'd0, host_done}, 32'd0);
        check("ready_after_done", {31'd0, host_ready}, 32'd1);
        if (op == OP_WRITE) check("wr_stream_mismatches", bad, 0);
    endtask

    initial begin
        logic e;
        int   l;
        int   dc;

        tbl[0] = '{OP_WRITE, 26'h0000123, 512, 0, 0, 1'b0};
        tbl[1] = '{OP_READ,  26'd7,       512, 0, 0, 1'b0};
        tbl[2] = '{OP_READ,  26'd9,       511, 0, 5, 1'b1};
        tbl[3] = '{OP_READ,  26'd10,      513, 0, 7, 1'b1};
        tbl[4] = '{OP_WRITE, 26'd11,      512, 1, 0, 1'b0};
        tbl[5] = '{OP_READ,  26'd12,      511, 1, 9, 1'b1};
        tbl[6] = '{OP_WRITE, 26'd13,      0,   0, 0, 1'b1};

        rst = 1'b1; host_addr = '0; host_wr_en = 1'b0; host_wdata = '0;
        host_req = 1'b0; host_op = 1'b0; host_sector = '0;
        incoming_byte = '0; finished_byte = 1'b0; finished_sector = 1'b0;
        ctrl_busy = 1'b0;
        repeat (3) tick();
        check("rst_host_done", {31'd0, host_done}, 32'd0);
        check("rst_host_err", {31'd0, host_err}, 32'd0);
        check("rst_execute", {31'd0, execute}, 32'd0);
        check("rst_op_code", {31'd0, op_code}, 32'd0);
        check("rst_sector", {6'd0, sector_address}, 32'd0);
        check("rst_outgoing", {24'd0, outgoing_byte}, 32'hFF);
        check("rst_rdata", {24'd0, host_rdata}, 32'd0);
        check("rst_ready", {31'd0, host_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Host fill: buf[i] = i[7:0]
        for (int i = 0; i < 512; i++) begin
            host_addr = 9'(i); host_wdata = 8'(i); host_wr_en = 1'b1;
            mdl[i] = 8'(i);
            tick();
        end
        host_wr_en = 1'b0;
        readback(0); readback(255); readback(256); readback(511);

        for (int r = 0; r < 7; r++) begin
            do_sector(tbl[r].op, tbl[r].sec, tbl[r].nbytes, tbl[r].mode, tbl[r].seed, e, l);
            check($sformatf("row%0d_done_latency", r), l, 1);
            check($sformatf("row%0d_host_err", r), {31'd0, e}, {31'd0, tbl[r].exp_err});
            readback(0); readback(100); readback(510); readback(511);
        end

        // Timeout: controller stalls after byte 10.
        do_sector(OP_READ, 26'd20, 10, 2, 11, e, l);
        check("timeout_latency", l, 100);
        check("timeout_err", {31'd0, e}, 32'd1);
        readback(9);

        // Read of sector 7 with (i*3)&0xFF: byte 100 must be 0x2C.
        do_sector(OP_READ, 26'd7, 512, 0, 0, e, l);
        check("read7_err", {31'd0, e}, 32'd0);
        host_addr = 9'd100;
        tick();
        check("read7_addr100", {24'd0, host_rdata}, 32'h2C);

        // Reset during byte 200 of a READ.
        host_req = 1'b1; host_op = OP_READ; host_sector = 26'd30;
        tick();
        host_req = 1'b0;
        tick();
        for (int i = 0; i < 199; i++) begin
            incoming_byte = pat(i, 1); finished_byte = 1'b1;
            tick();
            finished_byte = 1'b0;
            tick();
        end
        dc = done_count;
        incoming_byte = pat(199, 1); finished_byte = 1'b1; rst = 1'b1;
        tick();
        finished_byte = 1'b0; rst = 1'b0;
        check("rstx_execute", {31'd0, execute}, 32'd0);
        check("rstx_ready", {31'd0, host_ready}, 32'd1);
        check("rstx_done", {31'd0, host_done}, 32'd0);
        check("rstx_outgoing", {24'd0, outgoing_byte}, 32'hFF);
        repeat (4) tick();
        check("rstx_no_done_pulse", done_count, dc);

        // Request while controller busy is ignored.
        ctrl_busy = 1'b1;
        tick();
        check("busy_ready", {31'd0, host_ready}, 32'd0);
        host_req = 1'b1; host_op = OP_WRITE; host_sector = 26'd40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_no_execute", {31'd0, execute}, 32'd0);
        end
        host_req = 1'b0; ctrl_busy = 1'b0;
        tick();
        check("busy_after_execute", {31'd0, execute}, 32'd0);
        check("busy_after_ready", {31'd0, host_ready}, 32'd1);
        check("busy_op_code_kept", {31'd0, op_code}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
